// File: rtl/csr_file.sv
`default_nettype none
// ============================================================================
// Module   : csr_file
// Purpose  : LoongArch CSR file for the WB stage: combinational read, masked
//            write, exception/ertn update, countdown timer and interrupt logic.
// Revision : 1.0 - initial release
// ============================================================================
module csr_file #(
    parameter logic [31:0] COREID = 32'h0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        csr_re,
    input  logic [13:0] csr_num,
    output logic [31:0] csr_rvalue,
    input  logic        csr_we,
    input  logic [31:0] csr_wmask,
    input  logic [31:0] csr_wvalue,
    input  logic        wb_ex,
    input  logic [5:0]  wb_ecode,
    input  logic [8:0]  wb_esubcode,
    input  logic [31:0] wb_pc,
    input  logic [31:0] wb_vaddr,
    input  logic        ertn_flush,
    input  logic [7:0]  hw_int_in,
    input  logic        ipi_int_in,
    output logic [31:0] ex_entry,
    output logic [31:0] ertn_entry,
    output logic        has_int
);

    localparam logic [13:0] c_CRMD   = 14'h00;
    localparam logic [13:0] c_PRMD   = 14'h01;
    localparam logic [13:0] c_ECFG   = 14'h04;
    localparam logic [13:0] c_ESTAT  = 14'h05;
    localparam logic [13:0] c_ERA    = 14'h06;
    localparam logic [13:0] c_BADV   = 14'h07;
    localparam logic [13:0] c_EENTRY = 14'h0C;
    localparam logic [13:0] c_SAVE0  = 14'h30;
    localparam logic [13:0] c_SAVE1  = 14'h31;
    localparam logic [13:0] c_SAVE2  = 14'h32;
    localparam logic [13:0] c_SAVE3  = 14'h33;
    localparam logic [13:0] c_TID    = 14'h40;
    localparam logic [13:0] c_TCFG   = 14'h41;
    localparam logic [13:0] c_TVAL   = 14'h42;
    localparam logic [13:0] c_TICLR  = 14'h44;
    localparam logic [31:0] c_ONES   = 32'hFFFF_FFFF;

    logic [3:0]  crmd_q,   crmd_d;
    logic [2:0]  prmd_q,   prmd_d;
    logic [12:0] ecfg_q,   ecfg_d;
    logic [12:0] is_q,     is_d;
    logic [5:0]  ecode_q,  ecode_d;
    logic [8:0]  esub_q,   esub_d;
    logic [31:0] era_q,    era_d;
    logic [31:0] badv_q,   badv_d;
    logic [25:0] eentry_q, eentry_d;
    logic [31:0] save0_q,  save0_d;
    logic [31:0] save1_q,  save1_d;
    logic [31:0] save2_q,  save2_d;
    logic [31:0] save3_q,  save3_d;
    logic [31:0] tcfg_q,   tcfg_d;
    logic [31:0] tval_q,   tval_d;

    logic [31:0] w_wdata;
    logic        w_wr_en;
    logic        w_tcfg_wr;
    logic        w_ticlr;
    logic        w_timer_fire;
    logic        w_unused;

    assign w_unused = csr_re;

    // Read is a pure mux; csr_re is not needed to qualify it.
    always_comb begin
        csr_rvalue = 32'h0;
        case (csr_num)
            c_CRMD:   csr_rvalue = {28'h0, crmd_q};
            c_PRMD:   csr_rvalue = {29'h0, prmd_q};
            c_ECFG:   csr_rvalue = {19'h0, ecfg_q};
            c_ESTAT:  csr_rvalue = {1'b0, esub_q, ecode_q, 3'b0, is_q};
            c_ERA:    csr_rvalue = era_q;
            c_BADV:   csr_rvalue = badv_q;
            c_EENTRY: csr_rvalue = {eentry_q, 6'h0};
            c_SAVE0:  csr_rvalue = save0_q;
            c_SAVE1:  csr_rvalue = save1_q;
            c_SAVE2:  csr_rvalue = save2_q;
            c_SAVE3:  csr_rvalue = save3_q;
            c_TID:    csr_rvalue = COREID;
            c_TCFG:   csr_rvalue = tcfg_q;
            c_TVAL:   csr_rvalue = tval_q;
            default:  csr_rvalue = 32'h0;
        endcase
    end

    // The addressed CSR's read value is the "old" operand of the masked merge.
    assign w_wdata      = (csr_wvalue & csr_wmask) | (csr_rvalue & ~csr_wmask);
    assign w_wr_en      = csr_we & ~wb_ex & ~ertn_flush;
    assign w_tcfg_wr    = w_wr_en && (csr_num == c_TCFG);
    assign w_ticlr      = w_wr_en && (csr_num == c_TICLR) && csr_wvalue[0] && csr_wmask[0];
    assign w_timer_fire = tcfg_q[0] && (tval_q == 32'h0);

    always_comb begin
        crmd_d   = crmd_q;
        prmd_d   = prmd_q;
        ecfg_d   = ecfg_q;
        is_d     = is_q;
        ecode_d  = ecode_q;
        esub_d   = esub_q;
        era_d    = era_q;
        badv_d   = badv_q;
        eentry_d = eentry_q;
        save0_d  = save0_q;
        save1_d  = save1_q;
        save2_d  = save2_q;
        save3_d  = save3_q;
        tcfg_d   = tcfg_q;
        tval_d   = tval_q;

        if (ertn_flush) begin
            crmd_d[2:0] = prmd_q;
        end else if (wb_ex) begin
            prmd_d      = crmd_q[2:0];
            crmd_d[2:0] = 3'b000;
            ecode_d     = wb_ecode;
            esub_d      = wb_esubcode;
            era_d       = wb_pc;
            if (wb_ecode == 6'h08 || wb_ecode == 6'h09)
                badv_d = wb_vaddr;
        end else if (csr_we) begin
            case (csr_num)
                c_CRMD:   crmd_d    = w_wdata[3:0];
                c_PRMD:   prmd_d    = w_wdata[2:0];
                c_ECFG:   ecfg_d    = {w_wdata[12:11], 1'b0, w_wdata[9:0]};
                c_ESTAT:  is_d[1:0] = w_wdata[1:0];
                c_ERA:    era_d     = w_wdata;
                c_BADV:   badv_d    = w_wdata;
                c_EENTRY: eentry_d  = w_wdata[31:6];
                c_SAVE0:  save0_d   = w_wdata;
                c_SAVE1:  save1_d   = w_wdata;
                c_SAVE2:  save2_d   = w_wdata;
                c_SAVE3:  save3_d   = w_wdata;
                c_TCFG:   tcfg_d    = w_wdata;
                default:  ;
            endcase
        end

        is_d[9:2] = hw_int_in;
        is_d[10]  = 1'b0;
        is_d[12]  = ipi_int_in;
        // Expiry set takes precedence over a simultaneous TICLR clear.
        is_d[11]  = (is_q[11] & ~w_ticlr) | w_timer_fire;

        if (w_tcfg_wr) begin
            tval_d = {tcfg_d[31:2], 2'b00};
        end else if (tcfg_q[0]) begin
            if (tval_q == 32'h0 && tcfg_q[1])
                tval_d = {tcfg_q[31:2], 2'b00};
            else if (tval_q != c_ONES)
                tval_d = tval_q - 32'h1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            crmd_q   <= 4'h8;
            prmd_q   <= 3'h0;
            ecfg_q   <= 13'h0;
            is_q     <= 13'h0;
            ecode_q  <= 6'h0;
            esub_q   <= 9'h0;
            era_q    <= 32'h0;
            badv_q   <= 32'h0;
            eentry_q <= 26'h0;
            save0_q  <= 32'h0;
            save1_q  <= 32'h0;
            save2_q  <= 32'h0;
            save3_q  <= 32'h0;
            tcfg_q   <= 32'h0;
            tval_q   <= c_ONES;
        end else begin
            crmd_q   <= crmd_d;
            prmd_q   <= prmd_d;
            ecfg_q   <= ecfg_d;
            is_q     <= is_d;
            ecode_q  <= ecode_d;
            esub_q   <= esub_d;
            era_q    <= era_d;
            badv_q   <= badv_d;
            eentry_q <= eentry_d;
            save0_q  <= save0_d;
            save1_q  <= save1_d;
            save2_q  <= save2_d;
            save3_q  <= save3_d;
            tcfg_q   <= tcfg_d;
            tval_q   <= tval_d;
        end
    end

    assign ex_entry   = {eentry_q, 6'h0};
    assign ertn_entry = era_q;
    assign has_int    = crmd_q[2] & |(is_q & ecfg_q);

endmodule
`default_nettype wire
